// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared constants for the FIFO write-port arbiter: state encodings and parameter defaults.
package fifo_wr_arbiter_pkg;

  localparam logic [0:0] ARB_IDLE  = 1'b0;
  localparam logic [0:0] ARB_BURST = 1'b1;

  localparam int unsigned ARB_DEF_BURST_LEN = 4;
  localparam int unsigned ARB_DEF_CNT_W     = 16;

  // Counter width that still gives one bit when the range collapses to a single value.
  function automatic int unsigned arb_clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_rr_pick.sv
// Combinational round-robin picker: first requester strictly after 'last', cyclically.
module fifo_rr_pick #(
  parameter int unsigned NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0]         req,
  input  logic [$clog2(NUM_SRC)-1:0] last,
  output logic [NUM_SRC-1:0]         win_onehot,
  output logic [$clog2(NUM_SRC)-1:0] win_idx,
  output logic                       win_valid
);

  localparam int unsigned IDX_W = $clog2(NUM_SRC);

  int unsigned      cand;
  logic [IDX_W-1:0] cand_idx;

  always_comb begin
    win_onehot = '0;
    win_idx    = '0;
    win_valid  = 1'b0;
    cand       = 0;
    cand_idx   = '0;
    // Search order last+1 .. last+NUM_SRC, so 'last' itself is only chosen when alone.
    for (int unsigned i = 1; i <= NUM_SRC; i++) begin
      cand     = (32'(last) + i) % NUM_SRC;
      cand_idx = IDX_W'(cand);
      if (!win_valid && req[cand_idx]) begin
        win_valid            = 1'b1;
        win_idx              = cand_idx;
        win_onehot[cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter for the async FIFO write port (write clock domain).
// Optional per-source word counters are enabled by defining FIFO_ARB_CNT_EN.
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int unsigned NUM_SRC   = 4,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned BURST_LEN = ARB_DEF_BURST_LEN
`ifdef FIFO_ARB_CNT_EN
  ,
  parameter int unsigned CNT_W     = ARB_DEF_CNT_W
`endif
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  output logic [NUM_SRC-1:0]        src_ready,
  input  logic                      fifo_wr_full,
  output logic                      fifo_wr_req,
  output logic [DATA_W-1:0]         fifo_wr_data,
  output logic [NUM_SRC-1:0]        grant,
  output logic                      busy
`ifdef FIFO_ARB_CNT_EN
  ,
  output logic [NUM_SRC*CNT_W-1:0]  src_word_cnt
`endif
);

  localparam int unsigned      IDX_W     = $clog2(NUM_SRC);
  localparam int unsigned      BEAT_W    = arb_clog2_min1(BURST_LEN);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);

  logic [0:0]         state_q, state_d;
  logic [NUM_SRC-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;

  logic [NUM_SRC-1:0] pick_onehot;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_valid;

  logic               in_burst;
  logic               own_valid;
  logic [DATA_W-1:0]  own_data;

  fifo_rr_pick #(
    .NUM_SRC (NUM_SRC)
  ) u_pick (
    .req        (src_valid),
    .last       (last_q),
    .win_onehot (pick_onehot),
    .win_idx    (pick_idx),
    .win_valid  (pick_valid)
  );

  // 'last' doubles as the owner index while in BURST.
  assign in_burst  = (state_q == ARB_BURST);
  assign own_valid = src_valid[last_q];
  assign own_data  = src_data[last_q*DATA_W +: DATA_W];

  always_comb begin
    src_ready = '0;
    if (rstn && in_burst && !fifo_wr_full) begin
      src_ready[last_q] = 1'b1;
    end
  end

  assign fifo_wr_req  = rstn && in_burst && own_valid && !fifo_wr_full;
  assign fifo_wr_data = in_burst ? own_data : '0;
  assign grant        = grant_q;
  assign busy         = in_burst;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    beat_d  = beat_q;
    if (state_q == ARB_IDLE) begin
      if (pick_valid) begin
        state_d = ARB_BURST;
        grant_d = pick_onehot;
        last_d  = pick_idx;
        beat_d  = '0;
      end
    end else begin
      if (!own_valid) begin
        state_d = ARB_IDLE;
        grant_d = '0;
        beat_d  = '0;
      end else if (!fifo_wr_full) begin
        if (beat_q == BEAT_LAST) begin
          state_d = ARB_IDLE;
          grant_d = '0;
          beat_d  = '0;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      last_q  <= IDX_W'(NUM_SRC - 1);
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
    end
  end

`ifdef FIFO_ARB_CNT_EN
  logic [CNT_W-1:0] cnt_q [NUM_SRC];
  logic [CNT_W-1:0] cnt_d [NUM_SRC];

  // Saturating: holds at all-ones until the next reset.
  always_comb begin
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      cnt_d[i] = cnt_q[i];
      if (src_valid[i] && src_ready[i] && (cnt_q[i] != '1)) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (!rstn) begin
        cnt_q[i] <= '0;
      end else begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  always_comb begin
    src_word_cnt = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      src_word_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter (NUM_SRC=4, DATA_W=8, BURST_LEN=4).
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [3:0]  src_valid = '0;
  logic [31:0] src_data;
  logic [3:0]  src_ready;
  logic        fifo_wr_full = 1'b0;
  logic        fifo_wr_req;
  logic [7:0]  fifo_wr_data;
  logic [3:0]  grant;
  logic        busy;
`ifdef FIFO_ARB_CNT_EN
  logic [15:0] src_word_cnt;
`endif

  logic [3:0]  seq [4] = '{default: 4'd0};
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .NUM_SRC   (4),
    .DATA_W    (8),
    .BURST_LEN (4)
`ifdef FIFO_ARB_CNT_EN
    ,
    .CNT_W     (4)
`endif
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .src_valid    (src_valid),
    .src_data     (src_data),
    .src_ready    (src_ready),
    .fifo_wr_full (fifo_wr_full),
    .fifo_wr_req  (fifo_wr_req),
    .fifo_wr_data (fifo_wr_data),
    .grant        (grant),
    .busy         (busy)
`ifdef FIFO_ARB_CNT_EN
    ,
    .src_word_cnt (src_word_cnt)
`endif
  );

  // Each source offers {source id, word sequence number}; sequence advances on accept.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!rstn) seq[i] <= '0;
      else if (src_valid[i] && src_ready[i]) seq[i] <= seq[i] + 4'd1;
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) src_data[i*8 +: 8] = {4'(i), seq[i]};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  task automatic expect_cycle(input string tag, input logic [3:0] g, input logic req,
                              input logic [7:0] data);
    @(negedge clk);
    check({tag, " grant"}, 32'(grant), 32'(g));
    check({tag, " req"}, 32'(fifo_wr_req), 32'(req));
    if (req) check({tag, " data"}, 32'(fifo_wr_data), 32'(data));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset with every source requesting: nothing granted or written.
    src_valid = 4'b1111;
    rstn = 1'b0;
    for (int r = 0; r < 2; r++) begin
      tick();
      @(negedge clk);
      check("rst grant", 32'(grant), 32'd0);
      check("rst ready", 32'(src_ready), 32'd0);
      check("rst req", 32'(fifo_wr_req), 32'd0);
      check("rst busy", 32'(busy), 32'd0);
    end
    tick();
    rstn = 1'b1;
    expect_cycle("arb0", 4'b0000, 1'b0, 8'h00);
    tick();

    // Fairness: 4 writes per owner then one idle cycle, owners 0,1,2,3,0.
    for (int k = 0; k <= 20; k++) begin
      int owner;
      int pos;
      owner = (k / 5) % 4;
      pos   = k % 5;
      if (pos < 4)
        expect_cycle($sformatf("rr k%0d", k), 4'(1 << owner), 1'b1,
                     8'((owner << 4) + (k / 20) * 4 + pos));
      else
        expect_cycle($sformatf("rr k%0d", k), 4'b0000, 1'b0, 8'h00);
      tick();
    end

    // Full stall mid-burst, lone requester source 1.
    src_valid = 4'b0010;
    do_reset();
    expect_cycle("st idle", 4'b0000, 1'b0, 8'h00);
    tick();
    expect_cycle("st w0", 4'b0010, 1'b1, 8'h10);
    tick();
    expect_cycle("st w1", 4'b0010, 1'b1, 8'h11);
    tick();
    fifo_wr_full = 1'b1;
    for (int s = 0; s < 5; s++) begin
      expect_cycle($sformatf("st full%0d", s), 4'b0010, 1'b0, 8'h00);
      check("st ready", 32'(src_ready), 32'd0);
      tick();
    end
    fifo_wr_full = 1'b0;
    expect_cycle("st w2", 4'b0010, 1'b1, 8'h12);
    tick();
    expect_cycle("st w3", 4'b0010, 1'b1, 8'h13);
    tick();
    expect_cycle("st gap", 4'b0000, 1'b0, 8'h00);
    tick();
    expect_cycle("st regrant", 4'b0010, 1'b1, 8'h14);

    // Early release by owner 2, then by owner 3 (wrap to source 0).
    src_valid = 4'b0100;
    do_reset();
    expect_cycle("er idle", 4'b0000, 1'b0, 8'h00);
    tick();
    expect_cycle("er w0", 4'b0100, 1'b1, 8'h20);
    tick();
    src_valid = 4'b1000;
    expect_cycle("er drop2", 4'b0100, 1'b0, 8'h00);
    check("er busy", 32'(busy), 32'd1);
    tick();
    expect_cycle("er idle2", 4'b0000, 1'b0, 8'h00);
    tick();
    expect_cycle("er grant3", 4'b1000, 1'b1, 8'h30);
    tick();
    src_valid = 4'b0001;
    expect_cycle("er drop3", 4'b1000, 1'b0, 8'h00);
    tick();
    expect_cycle("er idle3", 4'b0000, 1'b0, 8'h00);
    tick();
    expect_cycle("er grant0", 4'b0001, 1'b1, 8'h00);

    // Reset asserted during beat 2 of a burst.
    src_valid = 4'b1111;
    do_reset();
    expect_cycle("mr idle", 4'b0000, 1'b0, 8'h00);
    tick();
    expect_cycle("mr w0", 4'b0001, 1'b1, 8'h00);
    tick();
    expect_cycle("mr w1", 4'b0001, 1'b1, 8'h01);
    tick();
    rstn = 1'b0;
    expect_cycle("mr rstcyc", 4'b0001, 1'b0, 8'h00);
    check("mr ready", 32'(src_ready), 32'd0);
    tick();
    rstn = 1'b1;
    expect_cycle("mr after", 4'b0000, 1'b0, 8'h00);
    check("mr busy", 32'(busy), 32'd0);
    tick();
    expect_cycle("mr regrant", 4'b0001, 1'b1, 8'h00);

`ifdef FIFO_ARB_CNT_EN
    // 20 words from source 1 saturate a 4-bit counter.
    src_valid = 4'b0010;
    do_reset();
    for (int c = 0; c < 26; c++) tick();
    @(negedge clk);
    check("cnt src1", 32'(src_word_cnt[7:4]), 32'd15);
    check("cnt src0", 32'(src_word_cnt[3:0]), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
